// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the pc_seq program sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    REL,
    ABS,
    POP
  } pc_sel_t;

  localparam int PC_W_DEF      = 10;
  localparam int OFF_W_DEF     = 8;
  localparam int HALT_ADDR_DEF = 63;
  localparam int STK_DEPTH_DEF = 4;
  localparam int LUT_DEPTH_DEF = 16;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_seq; push when full and pop when empty are ignored.
module pc_ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [W-1:0]    r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [PW-2:0]   w_wr_idx;
  logic [PW-2:0]   w_top_idx;

  assign full      = (r_ptr == PW'(DEPTH));
  assign empty     = (r_ptr == '0);
  assign w_wr_idx  = r_ptr[PW-2:0];
  assign w_top_idx = r_ptr[PW-2:0] - 1'b1;
  assign top       = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (push && !full) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

  // Entry storage carries no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program sequencer: start/run/halt control, branches, call/return stack.
// Optional absolute-target table enabled by defining PC_LUT_EN.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int OFF_W     = OFF_W_DEF,
  parameter int HALT_ADDR = HALT_ADDR_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         start,
  input  logic [PC_W-1:0]              start_address,
  input  logic                         stall,
  input  logic                         branch,
  input  logic                         taken,
  input  logic                         absolute,
  input  logic [OFF_W-1:0]             target,
  input  logic                         call,
  input  logic                         ret,
`ifdef PC_LUT_EN
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_addr,
  input  logic [PC_W-1:0]              lut_data,
`endif
  output logic [PC_W-1:0]              PC,
  output logic                         running,
  output logic                         halted,
  output logic                         stack_err
);

  localparam int              LAB     = $clog2(LUT_DEPTH);
  localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);

  state_t          r_state, w_state_nxt;
  pc_sel_t         w_sel;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_abs, w_top;
  logic [LAB-1:0]  w_idx;
  logic            r_err, w_err_set;
  logic            w_push, w_pop, w_clr, w_full, w_empty;

  function automatic logic [PC_W-1:0] f_rel(input logic [PC_W-1:0] pc,
                                            input logic [OFF_W-1:0] off);
    logic signed [PC_W-1:0] s_off;
    s_off = PC_W'($signed(off));
    return pc + s_off;
  endfunction

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_idx    = target[LAB-1:0];

`ifdef PC_LUT_EN
  logic [PC_W-1:0] r_lut [LUT_DEPTH];

  // Registered write, so a same-cycle jump to the written index sees the old entry.
  always_ff @(posedge CLK) begin
    if (lut_we) begin
      r_lut[lut_addr] <= lut_data;
    end
  end

  assign w_abs = r_lut[w_idx];
`else
  assign w_abs = PC_W'(w_idx);
`endif

  pc_ret_stack #(
    .W     (PC_W),
    .DEPTH (STK_DEPTH)
  ) u_stk (
    .clk   (CLK),
    .rst   (RESET),
    .clr   (w_clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .top   (w_top),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = HOLD;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_err_set   = 1'b0;
    if (start) begin
      w_state_nxt = RUN;
      w_clr       = 1'b1;
    end else if (r_state == RUN) begin
      if (r_pc == HALT_PC) begin
        w_state_nxt = HALT;
      end else if (stall) begin
        w_sel = HOLD;
      end else if (call && ret) begin
        w_err_set = 1'b1;
        w_sel     = INC;
      end else if (ret) begin
        if (w_empty) begin
          w_err_set = 1'b1;
          w_sel     = INC;
        end else begin
          w_pop = 1'b1;
          w_sel = POP;
        end
      end else if (call) begin
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_push = 1'b1;
        end
        w_sel = absolute ? ABS : REL;
      end else if (branch && taken) begin
        w_sel = absolute ? ABS : REL;
      end else begin
        w_sel = INC;
      end
    end
  end

  always_comb begin
    w_pc_nxt = r_pc;
    case (w_sel)
      INC:     w_pc_nxt = w_pc_inc;
      REL:     w_pc_nxt = f_rel(r_pc, target);
      ABS:     w_pc_nxt = w_abs;
      POP:     w_pc_nxt = w_top;
      default: w_pc_nxt = r_pc;
    endcase
    if (start) begin
      w_pc_nxt = start_address;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (start) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign PC        = r_pc;
  assign running   = (r_state == RUN);
  assign halted    = (r_state == HALT);
  assign stack_err = r_err;

endmodule
